lane_renderer: RTL

- Rasterises one lane of note slots into single-pixel writes for the 160x120 VGA adapter.
- Sits between the note-sequence logic, which supplies the per-slot red/yellow bit vectors, and the VGA adapter's x/y/colour/plot inputs.
- On each go pulse it draws SLOTS 4x4 squares left to right, one pixel per clock, then pulses done.

---
 rtl/lane_renderer_if.sv | 33 +++
 rtl/lane_renderer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lane_renderer_if.sv
// Lane renderer bus: note-sequence side (master) to renderer (slave) and
// renderer outputs toward the 160x120 VGA adapter.
//   go          start-frame request
//   red_seq     per-slot red note bits
//   yellow_seq  per-slot yellow note bits
//   start_x/y   top-left pixel of slot 0
//   x/y/colour  pixel write to the adapter, qualified by plot
//   busy/done   frame in progress / one-cycle completion pulse
interface lane_renderer_if #(
  parameter int unsigned SLOTS = 10
);
  logic             go;
  logic [SLOTS-1:0] red_seq;
  logic [SLOTS-1:0] yellow_seq;
  logic [7:0]       start_x;
  logic [6:0]       start_y;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [2:0]       colour;
  logic             plot;
  logic             busy;
  logic             done;

  modport master (
    output go, red_seq, yellow_seq, start_x, start_y,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  go, red_seq, yellow_seq, start_x, start_y,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/lane_renderer.sv
// lane_renderer: rasterises one lane of SLOTS note slots into 4x4 squares,
// one pixel per clock, for the 160x120 VGA adapter.
// Ports:
//   clk      system clock
//   resetn   asynchronous active-low reset
//   lane     lane_renderer_if.slave (go, note vectors, start position in;
//            x, y, colour, plot, busy, done out; all outputs registered)
// Optional build macro: LANE_RENDERER_ERASE_EN -- when defined, empty-slot
// pixels are written with BG_COL so stale notes are erased in the same pass.
module lane_renderer #(
  parameter int unsigned SLOTS      = 10,
  parameter int unsigned SLOT_PITCH = 6,
  parameter logic [2:0]  RED_COL    = 3'b100,
  parameter logic [2:0]  YEL_COL    = 3'b110,
  parameter logic [2:0]  BG_COL     = 3'b000
) (
  input logic            clk,
  input logic            resetn,
  lane_renderer_if.slave lane
);

  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [X_W-1:0]    SCREEN_W  = X_W'(160);
  localparam logic [Y_W-1:0]    SCREEN_H  = Y_W'(120);
  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(3);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Frame snapshot and raster counters
  logic [SLOTS-1:0]  red_q, red_d;
  logic [SLOTS-1:0]  yel_q, yel_d;
  logic [X_W-1:0]    sx_q, sx_d;
  logic [Y_W-1:0]    sy_q, sy_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [OFF_W-1:0]  xoff_q, xoff_d;
  logic [OFF_W-1:0]  yoff_q, yoff_d;

  // Registered outputs
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Current pixel, computed from the snapshot so timing never depends on data
  logic [X_W-1:0]   px_x;
  logic [Y_W-1:0]   px_y;
  logic             on_screen;
  logic             paint;
  logic [COL_W-1:0] px_col;
  logic             last_px;
  logic             start_frame;

  assign px_x = X_W'(32'(sx_q) + 32'(slot_q) * SLOT_PITCH + 32'(xoff_q));
  assign px_y = Y_W'(32'(sy_q) + 32'(yoff_q));
  assign on_screen = (px_x < SCREEN_W) && (px_y < SCREEN_H);
  assign last_px   = (xoff_q == OFF_LAST) && (yoff_q == OFF_LAST) && (slot_q == SLOT_LAST);

  // go is honoured in IDLE and at the edge that retires DONE, never mid-frame
  assign start_frame = lane.go && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Slot colour: red wins over yellow; empty handling depends on build
  always_comb begin
    px_col = BG_COL;
    paint  = 1'b0;
    if (red_q[slot_q]) begin
      px_col = RED_COL;
      paint  = 1'b1;
    end else if (yel_q[slot_q]) begin
      px_col = YEL_COL;
      paint  = 1'b1;
    end else begin
`ifdef LANE_RENDERER_ERASE_EN
      px_col = BG_COL;
      paint  = 1'b1;
`else
      px_col = BG_COL;
      paint  = 1'b0;
`endif
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (lane.go) state_d = S_DRAW;
      S_DRAW:  if (last_px) state_d = S_DONE;
      S_DONE:  state_d = lane.go ? S_DRAW : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    red_d    = red_q;
    yel_d    = yel_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    slot_d   = slot_q;
    xoff_d   = xoff_q;
    yoff_d   = yoff_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_DRAW: begin
        busy_d = 1'b1;
        plot_d = paint && on_screen;
        // x/y/colour only move on a real write; otherwise they hold
        if (paint && on_screen) begin
          x_d      = px_x;
          y_d      = px_y;
          colour_d = px_col;
        end
        // xoff inner, yoff outer, then next slot
        xoff_d = xoff_q + OFF_W'(1);
        if (xoff_q == OFF_LAST) begin
          yoff_d = yoff_q + OFF_W'(1);
          if (yoff_q == OFF_LAST) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase

    if (start_frame) begin
      red_d  = lane.red_seq;
      yel_d  = lane.yellow_seq;
      sx_d   = lane.start_x;
      sy_d   = lane.start_y;
      slot_d = '0;
      xoff_d = '0;
      yoff_d = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      red_q    <= '0;
      yel_q    <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      slot_q   <= '0;
      xoff_q   <= '0;
      yoff_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      red_q    <= red_d;
      yel_q    <= yel_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      slot_q   <= slot_d;
      xoff_q   <= xoff_d;
      yoff_q   <= yoff_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign lane.x      = x_q;
  assign lane.y      = y_q;
  assign lane.colour = colour_q;
  assign lane.plot   = plot_q;
  assign lane.busy   = busy_q;
  assign lane.done   = done_q;

endmodule
